apb_clk_cfg_bridge: RTL



---
 rtl/apb_clk_cfg_bridge_pkg.sv | 34 +++
 rtl/apb_clk_cfg_bridge_if.sv | 23 ++
 rtl/apb_clk_cfg_bridge_lock_sync.sv | 23 ++
 rtl/apb_clk_cfg_bridge.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/apb_clk_cfg_bridge_pkg.sv
// Shared types and constants for the APB clock-configuration bridge.
package clk_cfg_pkg;

    typedef enum logic [1:0] {
        TGT_SOC     = 2'd0,
        TGT_PER     = 2'd1,
        TGT_CLUSTER = 2'd2,
        TGT_STATUS  = 2'd3
    } tgt_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int TGT_LSB = 4;
    localparam int TGT_MSB = 5;
    localparam int ADD_LSB = 2;
    localparam int ADD_MSB = 3;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_0BAD;

    // Request vector layout is {cluster, per, soc}.
    function automatic logic [2:0] tgt_onehot(input tgt_e tgt);
        case (tgt)
            TGT_SOC:     return 3'b001;
            TGT_PER:     return 3'b010;
            TGT_CLUSTER: return 3'b100;
            default:     return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/apb_clk_cfg_bridge_if.sv
// APB signal bundle between the control-bus master and the clock-config bridge.
interface apb_clk_cfg_bridge_if #(
    parameter int APB_ADDR_WIDTH = 12
) ();
    logic [APB_ADDR_WIDTH-1:0] paddr_i;
    logic [31:0]               pwdata_i;
    logic                      pwrite_i;
    logic                      psel_i;
    logic                      penable_i;
    logic [31:0]               prdata_o;
    logic                      pready_o;
    logic                      pslverr_o;

    modport master (
        output paddr_i, pwdata_i, pwrite_i, psel_i, penable_i,
        input  prdata_o, pready_o, pslverr_o
    );

    modport slave (
        input  paddr_i, pwdata_i, pwrite_i, psel_i, penable_i,
        output prdata_o, pready_o, pslverr_o
    );
endinterface

// File: rtl/apb_clk_cfg_bridge_lock_sync.sv
// Two-flop synchronizer for the three clock-generator lock indicators.
module clk_cfg_lock_sync (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [2:0] lock_i,
    output logic [2:0] lock_o
);
    logic [2:0] meta_q;
    logic [2:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so both stages sample pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= lock_i;
            sync_q <= meta_q;
        end
    end

    assign lock_o = sync_q;
endmodule

// File: rtl/apb_clk_cfg_bridge.sv
// APB slave that turns each bus transfer into one soc/per/cluster clock-config req/ack transaction.
// Optional: define CLK_CFG_TIMEOUT_EN to abort a request left unacknowledged for TIMEOUT_CYCLES.
module apb_clk_cfg_bridge
    import clk_cfg_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    apb_clk_cfg_bridge_if.slave        apb,

    output logic                       soc_cfg_req_o,
    input  logic                       soc_cfg_ack_i,
    output logic [1:0]                 soc_cfg_add_o,
    output logic [31:0]                soc_cfg_data_o,
    input  logic [31:0]                soc_cfg_r_data_i,
    output logic                       soc_cfg_wrn_o,
    input  logic                       soc_cfg_lock_i,

    output logic                       per_cfg_req_o,
    input  logic                       per_cfg_ack_i,
    output logic [1:0]                 per_cfg_add_o,
    output logic [31:0]                per_cfg_data_o,
    input  logic [31:0]                per_cfg_r_data_i,
    output logic                       per_cfg_wrn_o,
    input  logic                       per_cfg_lock_i,

    output logic                       cluster_cfg_req_o,
    input  logic                       cluster_cfg_ack_i,
    output logic [1:0]                 cluster_cfg_add_o,
    output logic [31:0]                cluster_cfg_data_o,
    input  logic [31:0]                cluster_cfg_r_data_i,
    output logic                       cluster_cfg_wrn_o,
    input  logic                       cluster_cfg_lock_i
);

    state_e      state_q, state_d;
    tgt_e        tgt_q;
    logic [2:0]  req_q;
    logic [1:0]  add_q;
    logic [31:0] data_q;
    logic        wrn_q;
    logic [31:0] prdata_q;
    logic        pslverr_q;

    logic [2:0]  lock_sync;
    tgt_e        addr_tgt;
    logic        access;
    logic        ack_sel;
    logic [31:0] rdata_sel;
    logic        timeout_hit;

    logic unused_paddr;
    assign unused_paddr = ^{apb.paddr_i[APB_ADDR_WIDTH-1:TGT_MSB+1], apb.paddr_i[ADD_LSB-1:0]};

    clk_cfg_lock_sync u_lock_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .lock_i ({cluster_cfg_lock_i, per_cfg_lock_i, soc_cfg_lock_i}),
        .lock_o (lock_sync)
    );

    assign addr_tgt = tgt_e'(apb.paddr_i[TGT_MSB:TGT_LSB]);
    assign access   = apb.psel_i & apb.penable_i;

    // NOTE: every signal written in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        ack_sel   = 1'b0;
        rdata_sel = '0;
        case (tgt_q)
            TGT_SOC: begin
                ack_sel   = soc_cfg_ack_i;
                rdata_sel = soc_cfg_r_data_i;
            end
            TGT_PER: begin
                ack_sel   = per_cfg_ack_i;
                rdata_sel = per_cfg_r_data_i;
            end
            TGT_CLUSTER: begin
                ack_sel   = cluster_cfg_ack_i;
                rdata_sel = cluster_cfg_r_data_i;
            end
            default: ;
        endcase
    end

`ifdef CLK_CFG_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] req_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_cnt_q <= '0;
        end else if (state_q != ST_REQ) begin
            req_cnt_q <= '0;
        end else begin
            req_cnt_q <= req_cnt_q + 1'b1;
        end
    end

    // The counter is zero on the first REQ cycle, so this flags the TIMEOUT_CYCLES-th one.
    assign timeout_hit = (state_q == ST_REQ) && (req_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    state_d = (addr_tgt == TGT_STATUS) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_sel || timeout_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request, transaction fields and response are all registered; ack takes priority over timeout.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tgt_q     <= TGT_SOC;
            req_q     <= '0;
            add_q     <= '0;
            data_q    <= '0;
            wrn_q     <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (access) begin
                        if (addr_tgt == TGT_STATUS) begin
                            prdata_q  <= apb.pwrite_i ? 32'h0 : {29'b0, lock_sync};
                            pslverr_q <= apb.pwrite_i;
                        end else begin
                            tgt_q     <= addr_tgt;
                            add_q     <= apb.paddr_i[ADD_MSB:ADD_LSB];
                            data_q    <= apb.pwdata_i;
                            wrn_q     <= ~apb.pwrite_i;
                            req_q     <= tgt_onehot(addr_tgt);
                            pslverr_q <= 1'b0;
                        end
                    end
                end
                ST_REQ: begin
                    if (ack_sel) begin
                        req_q    <= '0;
                        prdata_q <= wrn_q ? rdata_sel : 32'h0;
                    end else if (timeout_hit) begin
                        req_q     <= '0;
                        prdata_q  <= TIMEOUT_RDATA;
                        pslverr_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        apb.pready_o       = (state_q == ST_DONE);
        apb.prdata_o       = prdata_q;
        apb.pslverr_o      = pslverr_q;

        soc_cfg_req_o      = req_q[0];
        per_cfg_req_o      = req_q[1];
        cluster_cfg_req_o  = req_q[2];

        soc_cfg_add_o      = add_q;
        per_cfg_add_o      = add_q;
        cluster_cfg_add_o  = add_q;
        soc_cfg_data_o     = data_q;
        per_cfg_data_o     = data_q;
        cluster_cfg_data_o = data_q;
        soc_cfg_wrn_o      = wrn_q;
        per_cfg_wrn_o      = wrn_q;
        cluster_cfg_wrn_o  = wrn_q;
    end

endmodule
